// File: rtl/idsb_pkg.sv
// Shared defaults and types for the ID-stage pending-write scoreboard.
package idsb_pkg;

  localparam int REG_NUM_DEF = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int CNT_W_DEF   = 2;

  // Most writers that may be in flight to one register at the default width.
  localparam int CNT_MAX = (1 << CNT_W_DEF) - 1;

  typedef logic [REG_AW_DEF-1:0] reg_idx_t;
  typedef logic [CNT_W_DEF-1:0]  cnt_t;

endpackage : idsb_pkg

// File: rtl/idsb_regcnt.sv
// Pending-writer counter for one architectural register: up on issue, down on
// retire, synchronous clear on flush. ID_SCOREBOARD_WB_BYPASS_EN adds is_one_o.
module idsb_regcnt #(
  parameter int CNT_W = idsb_pkg::CNT_W_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
`ifdef ID_SCOREBOARD_WB_BYPASS_EN
  output logic is_one_o,
`endif
  output logic is_zero_o,
  output logic is_max_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign is_zero_o = (cnt_q == '0);
  assign is_max_o  = (cnt_q == '1);
`ifdef ID_SCOREBOARD_WB_BYPASS_EN
  assign is_one_o  = (cnt_q == CNT_W'(1));
`endif

  // Simultaneous inc and dec cancel; the bounds guards keep a protocol slip
  // from wrapping the count (an underflow is flagged by the parent).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && !is_max_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && !is_zero_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : idsb_regcnt

// File: rtl/id_scoreboard.sv
// ID-stage issue gate built on per-register pending-write counters.
// Optional write-through bypass of the retiring register: ID_SCOREBOARD_WB_BYPASS_EN.
module id_scoreboard
  import idsb_pkg::*;
#(
  parameter int REG_NUM  = REG_NUM_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int RD_PORTS = 2,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PERF_W   = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       id_valid,
  input  logic [RD_PORTS-1:0]        id_rs_used,
  input  logic [RD_PORTS*REG_AW-1:0] id_rs,
  input  logic                       id_we,
  input  logic [REG_AW-1:0]          id_wnum,
  output logic                       id_ready,
  input  logic                       wb_valid,
  input  logic                       wb_we,
  input  logic [REG_AW-1:0]          wb_wnum,
  input  logic                       flush,
  output logic [REG_NUM-1:0]         busy_vec,
  output logic [PERF_W-1:0]          stall_cnt,
  output logic                       sb_err
);

  // Status vectors span the whole index space so any encodable index can be
  // looked up; r0 and indices at or above REG_NUM read as idle.
  localparam int IDX_NUM = 1 << REG_AW;

  logic [IDX_NUM-1:0]  zero_vec;
  logic [IDX_NUM-1:0]  max_vec;
  logic [IDX_NUM-1:0]  inc_vec;
  logic [IDX_NUM-1:0]  dec_vec;
`ifdef ID_SCOREBOARD_WB_BYPASS_EN
  logic [IDX_NUM-1:0]  one_vec;
`endif

  logic [RD_PORTS-1:0] src_haz;
  logic                raw_hazard;
  logic                sat_hazard;
  logic                issue;
  logic                ret;
  logic                err_set;
  logic                stall_inc;

  logic [PERF_W-1:0]   stall_cnt_q;
  logic [PERF_W-1:0]   stall_cnt_d;
  logic                sb_err_q;
  logic                sb_err_d;

  assign ret   = wb_valid && wb_we && (wb_wnum != '0);
  assign issue = id_valid && id_ready;

  for (genvar g = 0; g < IDX_NUM; g++) begin : g_reg
    assign inc_vec[g] = issue && id_we && (id_wnum == REG_AW'(g));
    assign dec_vec[g] = ret && (wb_wnum == REG_AW'(g));

    if (g >= 1 && g < REG_NUM) begin : g_trk
      idsb_regcnt #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .inc_i     (inc_vec[g]),
        .dec_i     (dec_vec[g]),
        .clr_i     (flush),
`ifdef ID_SCOREBOARD_WB_BYPASS_EN
        .is_one_o  (one_vec[g]),
`endif
        .is_zero_o (zero_vec[g]),
        .is_max_o  (max_vec[g])
      );
    end else begin : g_idle
      assign zero_vec[g] = 1'b1;
      assign max_vec[g]  = 1'b0;
`ifdef ID_SCOREBOARD_WB_BYPASS_EN
      assign one_vec[g]  = 1'b0;
`endif
    end
  end

  // A source is a hazard while any older writer of it is still in flight.
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_src
    logic [REG_AW-1:0] rs_idx;
    assign rs_idx = id_rs[i*REG_AW +: REG_AW];
`ifdef ID_SCOREBOARD_WB_BYPASS_EN
    // The last outstanding writer retiring now is visible through the
    // write-through regfile, so it no longer blocks the read.
    assign src_haz[i] = id_rs_used[i] && (rs_idx != '0) && !zero_vec[rs_idx]
                        && !(one_vec[rs_idx] && ret && (wb_wnum == rs_idx));
`else
    assign src_haz[i] = id_rs_used[i] && (rs_idx != '0) && !zero_vec[rs_idx];
`endif
  end

  assign raw_hazard = |src_haz;

`ifdef ID_SCOREBOARD_WB_BYPASS_EN
  assign sat_hazard = id_we && (id_wnum != '0) && max_vec[id_wnum]
                      && !(ret && (wb_wnum == id_wnum));
`else
  assign sat_hazard = id_we && (id_wnum != '0) && max_vec[id_wnum];
`endif

  assign id_ready = !raw_hazard && !sat_hazard && !flush;

  // A retire with nothing outstanding means the pipeline lost track of a
  // writer; a same-cycle issue to that register supplies the missing count.
  assign err_set   = ret && zero_vec[wb_wnum] && !inc_vec[wb_wnum];
  assign stall_inc = id_valid && !id_ready && !flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
    sb_err_d = sb_err_q || err_set;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign busy_vec  = ~zero_vec[REG_NUM-1:0];
  assign stall_cnt = stall_cnt_q;
  assign sb_err    = sb_err_q;

endmodule : id_scoreboard
